// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared pipeline definitions: occupancy-encoded state enum, the RV32 NOP
// constant used for bubble payloads, and per-stage payload widths.
package pipe_pkg;

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL2 = 2'd2
  } pipe_state_e;

  // addi x0, x0, 0 -- the canonical RV32 bubble instruction.
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  // Payload widths of the standard RV32IM stage boundaries.
  localparam int IFID_W  = 64;   // {pc, instr}
  localparam int IDEX_W  = 160;  // {pc, rs1_val, rs2_val, imm, ctrl}
  localparam int EXMEM_W = 104;  // {alu_res, rs2_val, rd, ctrl}
  localparam int MEMWB_W = 72;   // {wb_val, rd, ctrl}

  // Number of held entries for a state value; the unused encoding maps to 0.
  function automatic logic [1:0] state_occupancy(input logic [1:0] st);
    logic [1:0] occ;
    occ = (st == FULL2) ? 2'd2 :
          (st == ONE)   ? 2'd1 : 2'd0;
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Producer/consumer handshake bundle of one pipeline stage register.
//
// Handshake: a beat moves on a rising clk edge exactly when valid and ready
// are both high in the cycle before it (in_valid & in_ready on the producer
// side, out_valid & out_ready on the consumer side). A producer holding
// in_valid keeps in_data stable until the beat moves; the stage keeps
// out_data stable while out_valid is high and out_ready is low.
interface pipe_stage_skid_reg_if #(
  parameter int DATA_W = 64
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  // Environment side: drives producer payload and consumer ready.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Stage side: the pipe_stage_skid_reg instance.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Handshaked pipeline stage register with an optional 2-entry skid buffer,
// flush-to-bubble and a global busywait freeze. Entry "main" is always the
// head presented on out_data; "skid" only holds the second entry in FULL2.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W     = 64,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  parameter bit              SKID_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 busywait,
  input  logic                 flush,
  pipe_stage_skid_reg_if.slave bus,
  output logic [1:0]           occupancy,
  output logic [1:0]           state_dbg
);

  localparam logic [1:0] S_EMPTY = EMPTY;
  localparam logic [1:0] S_ONE   = ONE;
  localparam logic [1:0] S_FULL2 = FULL2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q,  main_d;
  logic [DATA_W-1:0] skid_q,  skid_d;

  logic main_valid;
  logic in_ready_w;
  logic out_valid_w;
  logic in_fire;
  logic out_fire;

  // Handshake outputs. With the skid buffer in_ready depends on registered
  // state and busywait only; without it, ready passes back combinationally.
  always_comb begin
    main_valid = (state_q != S_EMPTY);
    if (SKID_EN) begin
      in_ready_w = (state_q != S_FULL2) & ~busywait;
    end else begin
      in_ready_w = (bus.out_ready | ~main_valid) & ~busywait;
    end
    out_valid_w = main_valid & ~busywait;
    in_fire     = bus.in_valid & in_ready_w;
    out_fire    = out_valid_w & bus.out_ready;
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = main_q;
  assign occupancy     = state_occupancy(state_q);
  assign state_dbg     = state_q;

  // Next-state logic. busywait forces both fires low, so every register
  // holds without a dedicated branch; flush still takes effect during it.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A concurrent in_fire is dropped; a concurrent out_fire has already
      // been consumed downstream, so emptying is all that is needed.
      state_d = S_EMPTY;
      main_d  = RESET_DATA;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_ONE;
            main_d  = bus.in_data;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = bus.in_data;
          end else if (in_fire) begin
            // Without the skid buffer in_ready implies out_fire here, so
            // this branch is only reachable when SKID_EN is set.
            if (SKID_EN) begin
              state_d = S_FULL2;
              skid_d  = bus.in_data;
            end
          end else if (out_fire) begin
            // main keeps its last value; out_valid is low so it is unseen.
            state_d = S_EMPTY;
          end
        end
        S_FULL2: begin
          if (out_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          // Unused encoding: recover to a clean bubble.
          state_d = S_EMPTY;
          main_d  = RESET_DATA;
          skid_d  = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= RESET_DATA;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: a directed vector table, hand-written
// corner sequences and random traffic against a queue-based reference.
module tb_pipe_stage_skid_reg;
  import pipe_pkg::*;

  localparam int          W  = 64;
  localparam logic [63:0] RD = {32'h0, RV32_NOP};

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic       busywait;
  logic       flush;
  logic [1:0] occupancy;
  logic [1:0] state_dbg;

  pipe_stage_skid_reg_if #(.DATA_W(W)) bus ();

  pipe_stage_skid_reg #(
    .DATA_W    (W),
    .RESET_DATA(RD),
    .SKID_EN   (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .busywait (busywait),
    .flush    (flush),
    .bus      (bus),
    .occupancy(occupancy),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic f, input logic bw, input logic iv,
                       input logic [63:0] d, input logic ordy);
    @(negedge clk);
    rst           = r;
    flush         = f;
    busywait      = bw;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        r, f, bw, iv;
    logic [63:0] d;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [63:0] e_od;
    logic [1:0]  e_occ;
    logic        c;
  } vec_t;

  function automatic vec_t mk(input logic r, f, bw, iv, input logic [63:0] d,
                              input logic ordy, input logic e_ir, e_ov,
                              input logic [63:0] e_od, input logic [1:0] e_occ,
                              input logic c);
    vec_t v;
    v.r = r; v.f = f; v.bw = bw; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.c = c;
    return v;
  endfunction

  vec_t tbl[36];

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the accepted-but-not-delivered beats in FIFO order; shown is
  // the value the stage presents on out_data (head, or last head / bubble).
  logic [W-1:0] exp_q[$];
  logic [W-1:0] shown;

  task automatic step_m(input logic r, input logic f, input logic bw, input logic iv,
                        input logic [63:0] d, input logic ordy);
    int          e_occ;
    logic        e_ir, e_ov, ifire, ofire;
    drive(r, f, bw, iv, d, ordy);
    e_occ = exp_q.size();
    e_ir  = (e_occ < 2) && !bw;
    e_ov  = (e_occ > 0) && !bw;
    chk("m_in_ready",  64'(bus.in_ready),  64'(e_ir));
    chk("m_out_valid", 64'(bus.out_valid), 64'(e_ov));
    chk("m_out_data",  bus.out_data,       shown);
    chk("m_occupancy", 64'(occupancy),     64'(e_occ));
    ifire = iv && e_ir;
    ofire = e_ov && ordy;
    @(posedge clk);
    if (r || f) begin
      exp_q.delete();
      shown = RD;
    end else begin
      if (ofire) void'(exp_q.pop_front());
      if (ifire) exp_q.push_back(d);
      if (exp_q.size() > 0) shown = exp_q[0];
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; busywait = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    //            r f b iv d       or  ir ov od      occ c
    tbl[0]  = mk(1,0,0,1, 64'hA,  0,  1, 0, RD,     0, 0);
    tbl[1]  = mk(1,0,0,1, 64'hA,  0,  1, 0, RD,     0, 1);
    tbl[2]  = mk(0,0,0,0, 64'h0,  0,  1, 0, RD,     0, 1);
    tbl[3]  = mk(0,0,0,1, 64'h1,  1,  1, 0, RD,     0, 1);
    tbl[4]  = mk(0,0,0,1, 64'h2,  1,  1, 1, 64'h1,  1, 1);
    tbl[5]  = mk(0,0,0,1, 64'h3,  1,  1, 1, 64'h2,  1, 1);
    tbl[6]  = mk(0,0,0,1, 64'h4,  1,  1, 1, 64'h3,  1, 1);
    tbl[7]  = mk(0,0,0,0, 64'h0,  1,  1, 1, 64'h4,  1, 1);
    tbl[8]  = mk(0,0,0,0, 64'h0,  0,  1, 0, 64'h4,  0, 1);
    tbl[9]  = mk(0,0,0,1, 64'h5,  0,  1, 0, 64'h4,  0, 1);
    tbl[10] = mk(0,0,0,1, 64'h6,  0,  1, 1, 64'h5,  1, 1);
    tbl[11] = mk(0,0,0,1, 64'h99, 0,  0, 1, 64'h5,  2, 1);
    tbl[12] = mk(0,0,0,0, 64'h0,  1,  0, 1, 64'h5,  2, 1);
    tbl[13] = mk(0,0,0,0, 64'h0,  1,  1, 1, 64'h6,  1, 1);
    tbl[14] = mk(0,0,0,0, 64'h0,  0,  1, 0, 64'h6,  0, 1);
    tbl[15] = mk(0,0,0,1, 64'h7,  0,  1, 0, 64'h6,  0, 1);
    tbl[16] = mk(0,0,0,1, 64'h8,  0,  1, 1, 64'h7,  1, 1);
    tbl[17] = mk(0,1,0,1, 64'h9,  0,  0, 1, 64'h7,  2, 1);
    tbl[18] = mk(0,0,0,0, 64'h0,  1,  1, 0, RD,     0, 1);
    tbl[19] = mk(0,0,0,1, 64'hA,  0,  1, 0, RD,     0, 1);
    tbl[20] = mk(0,0,1,1, 64'hB,  1,  0, 0, 64'hA,  1, 1);
    tbl[21] = mk(0,0,1,1, 64'hB,  1,  0, 0, 64'hA,  1, 1);
    tbl[22] = mk(0,0,1,1, 64'hB,  1,  0, 0, 64'hA,  1, 1);
    tbl[23] = mk(0,0,0,0, 64'h0,  1,  1, 1, 64'hA,  1, 1);
    tbl[24] = mk(0,0,0,0, 64'h0,  1,  1, 0, 64'hA,  0, 1);
    tbl[25] = mk(0,0,0,1, 64'hC,  0,  1, 0, 64'hA,  0, 1);
    tbl[26] = mk(0,1,1,1, 64'hD,  1,  0, 0, 64'hC,  1, 1);
    tbl[27] = mk(0,0,1,0, 64'h0,  0,  0, 0, RD,     0, 1);
    tbl[28] = mk(0,0,0,0, 64'h0,  1,  1, 0, RD,     0, 1);
    tbl[29] = mk(0,0,0,1, 64'hE,  1,  1, 0, RD,     0, 1);
    tbl[30] = mk(0,1,0,0, 64'h0,  1,  1, 1, 64'hE,  1, 1);
    tbl[31] = mk(0,0,0,0, 64'h0,  0,  1, 0, RD,     0, 1);
    tbl[32] = mk(0,0,0,1, 64'hF,  0,  1, 0, RD,     0, 1);
    tbl[33] = mk(0,0,0,1, 64'h10, 0,  1, 1, 64'hF,  1, 1);
    tbl[34] = mk(1,0,0,0, 64'h0,  0,  0, 1, 64'hF,  2, 1);
    tbl[35] = mk(0,0,0,0, 64'h0,  0,  1, 0, RD,     0, 1);

    for (int i = 0; i < 36; i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].bw, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      if (tbl[i].c) begin
        chk($sformatf("t%0d_in_ready", i),  64'(bus.in_ready),  64'(tbl[i].e_ir));
        chk($sformatf("t%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_ov));
        chk($sformatf("t%0d_out_data", i),  bus.out_data,       tbl[i].e_od);
        chk($sformatf("t%0d_occupancy", i), 64'(occupancy),     64'(tbl[i].e_occ));
      end
      @(posedge clk);
    end

    // Table ends with the stage reset and idle: the model starts empty.
    exp_q.delete();
    shown = RD;

    // Hand-written: fill both entries, then stream with both sides ready.
    step_m(0, 0, 0, 1, 64'h20, 0);
    step_m(0, 0, 0, 1, 64'h21, 0);
    for (int k = 0; k < 5; k++) step_m(0, 0, 0, 1, 64'h22 + 64'(k), 1);
    // Freeze while full, then release and drain.
    step_m(0, 0, 0, 1, 64'h30, 0);
    for (int k = 0; k < 3; k++) step_m(0, 0, 1, 1, 64'h31, 1);
    for (int k = 0; k < 4; k++) step_m(0, 0, 0, 0, 64'h0, 1);
    // Long backpressure: out_data must hold while waiting.
    step_m(0, 0, 0, 1, 64'h40, 0);
    for (int k = 0; k < 4; k++) step_m(0, 0, 0, 1, 64'h41, 0);
    step_m(0, 0, 0, 0, 64'h0, 1);
    step_m(0, 0, 0, 0, 64'h0, 1);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      logic        r_r, r_f, r_bw, r_iv, r_or;
      logic [63:0] r_d;
      r_r  = ($urandom_range(0, 99) == 0);
      r_f  = ($urandom_range(0, 19) == 0);
      r_bw = ($urandom_range(0, 4) == 0);
      r_iv = ($urandom_range(0, 3) != 0);
      r_or = ($urandom_range(0, 2) != 0);
      r_d  = {$urandom, $urandom};
      step_m(r_r, r_f, r_bw, r_iv, r_d, r_or);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
